// File: rtl/drac_pkg.sv
// Shared types for the exe-stage SIMD units: element width encoding, divider FSM states
// and the width decode helper.
package drac_pkg;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2,
    SEW_64 = 2'd3
  } sew_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } simd_div_state_t;

  localparam int unsigned SIMD_DIV_XLEN = 64;

  function automatic int unsigned sew_bits(sew_t sew);
    case (sew)
      SEW_8:   sew_bits = 8;
      SEW_16:  sew_bits = 16;
      SEW_32:  sew_bits = 32;
      default: sew_bits = 64;
    endcase
  endfunction

endpackage

// File: rtl/simd_div_step.sv
// Combinational block of BITS_PER_CYCLE restoring-division steps applied to every lane of
// a packed 64-bit word; lanes are isolated so no bit ever crosses a lane boundary.
module simd_div_step
  import drac_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic [63:0] rem_i,
  input  logic [63:0] dq_i,
  input  logic [63:0] divisor_i,
  input  sew_t        sew_i,
  output logic [63:0] rem_o,
  output logic [63:0] dq_o
);

  genvar gj, gs, gi;

  for (gj = 0; gj < BITS_PER_CYCLE; gj++) begin : g_step
    logic [63:0]      r_in, d_in, r_out, d_out;
    logic [3:0][63:0] rem_s, dq_s;

    if (gj == 0) begin : g_first
      assign r_in = rem_i;
      assign d_in = dq_i;
    end else begin : g_chain
      assign r_in = g_step[gj-1].r_out;
      assign d_in = g_step[gj-1].d_out;
    end

    // One candidate result per element width; the latched sew picks the live one.
    for (gs = 0; gs < 4; gs++) begin : g_sew
      localparam int unsigned W = 8 << gs;
      for (gi = 0; gi < 64 / W; gi++) begin : g_lane
        logic [W-1:0] shifted;
        logic [W-1:0] div;
        logic         ge;
        assign div     = divisor_i[gi*W +: W];
        assign shifted = {r_in[gi*W +: W-1], d_in[gi*W+W-1]};
        assign ge      = (shifted >= div);
        assign rem_s[gs][gi*W +: W] = ge ? (shifted - div) : shifted;
        assign dq_s[gs][gi*W +: W]  = {d_in[gi*W +: W-1], ge};
      end
    end

    assign r_out = rem_s[sew_i];
    assign d_out = dq_s[sew_i];
  end

  assign rem_o = g_step[BITS_PER_CYCLE-1].r_out;
  assign dq_o  = g_step[BITS_PER_CYCLE-1].d_out;

endmodule

// File: rtl/simd_div_iter.sv
// Multi-cycle packed SIMD divider: IDLE -> PREP -> ITER -> FIX -> DONE, with per-lane sign
// handling, RISC-V divide-by-zero / signed-overflow results and valid/ready on both sides.
module simd_div_iter
  import drac_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [63:0] dividend_i,
  input  logic [63:0] divisor_i,
  input  sew_t        sew_i,
  input  logic        signed_i,
  input  logic        rem_i,
  input  logic        kill_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [63:0] result_o
);

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
        BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)) begin : g_bad_bpc
    $error("simd_div_iter: BITS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  localparam int unsigned CNT_W = 6;

  simd_div_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sew_t        sew_q, sew_d;
  logic        sgn_q, sgn_d;
  logic        rem_sel_q, rem_sel_d;
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  logic [63:0] rem_q, rem_d;
  logic [63:0] dq_q, dq_d;
  logic [7:0]  qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d, ov_q, ov_d;
  logic [63:0] result_q, result_d;

  logic [3:0][63:0] prep_a, prep_b, fix_res;
  logic [3:0][7:0]  prep_qneg, prep_rneg, prep_dz, prep_ov;
  logic [63:0]      step_rem, step_dq;

  genvar gs, gi;

  for (gs = 0; gs < 4; gs++) begin : g_sew
    localparam int unsigned W = 8 << gs;
    localparam int unsigned N = 64 / W;
    if (N < 8) begin : g_pad
      assign prep_qneg[gs][7:N] = '0;
      assign prep_rneg[gs][7:N] = '0;
      assign prep_dz[gs][7:N]   = '0;
      assign prep_ov[gs][7:N]   = '0;
    end
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [W-1:0] op_a, op_b, q_raw, r_raw, q_fix, r_fix;
      logic         sa, sb;
      assign op_a = a_q[gi*W +: W];
      assign op_b = b_q[gi*W +: W];
      assign sa   = sgn_q & op_a[W-1];
      assign sb   = sgn_q & op_b[W-1];

      assign prep_a[gs][gi*W +: W] = sa ? -op_a : op_a;
      assign prep_b[gs][gi*W +: W] = sb ? -op_b : op_b;
      assign prep_qneg[gs][gi]     = sa ^ sb;
      assign prep_rneg[gs][gi]     = sa;
      assign prep_dz[gs][gi]       = (op_b == '0);
      assign prep_ov[gs][gi]       = sgn_q && (op_a == {1'b1, {(W-1){1'b0}}}) && (op_b == '1);

      // a_q still holds the original dividend, which both special cases return.
      assign q_raw = dq_q[gi*W +: W];
      assign r_raw = rem_q[gi*W +: W];
      assign q_fix = dz_q[gi] ? '1 : ov_q[gi] ? op_a : qneg_q[gi] ? -q_raw : q_raw;
      assign r_fix = dz_q[gi] ? op_a : ov_q[gi] ? '0 : rneg_q[gi] ? -r_raw : r_raw;
      assign fix_res[gs][gi*W +: W] = rem_sel_q ? r_fix : q_fix;
    end
  end

  simd_div_step #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .rem_i    (rem_q),
    .dq_i     (dq_q),
    .divisor_i(b_q),
    .sew_i    (sew_q),
    .rem_o    (step_rem),
    .dq_o     (step_dq)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sew_d     = sew_q;
    sgn_d     = sgn_q;
    rem_sel_d = rem_sel_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    dq_d      = dq_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    ov_d      = ov_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          state_d   = PREP;
          a_d       = dividend_i;
          b_d       = divisor_i;
          sew_d     = sew_i;
          sgn_d     = signed_i;
          rem_sel_d = rem_i;
        end
      end
      PREP: begin
        state_d = ITER;
        cnt_d   = CNT_W'(sew_bits(sew_q) / BITS_PER_CYCLE - 1);
        dq_d    = prep_a[sew_q];
        b_d     = prep_b[sew_q];
        rem_d   = '0;
        qneg_d  = prep_qneg[sew_q];
        rneg_d  = prep_rneg[sew_q];
        dz_d    = prep_dz[sew_q];
        ov_d    = prep_ov[sew_q];
      end
      ITER: begin
        rem_d = step_rem;
        dq_d  = step_dq;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        result_d = fix_res[sew_q];
        state_d  = DONE;
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over everything, including a same-cycle accept or result handoff.
    if (kill_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sew_q     <= SEW_8;
      sgn_q     <= 1'b0;
      rem_sel_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      dq_q      <= '0;
      qneg_q    <= '0;
      rneg_q    <= '0;
      dz_q      <= '0;
      ov_q      <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sew_q     <= sew_d;
      sgn_q     <= sgn_d;
      rem_sel_q <= rem_sel_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      dq_q      <= dq_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      dz_q      <= dz_d;
      ov_q      <= ov_d;
      result_q  <= result_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;

endmodule
